escalonador_somador: RTL and testbench

Round-robin scheduler that shares one summation unit among NREQ requesters. Each requester posts a W-bit operand with a level request. The scheduler grants one requester, drives the unit's start/operand handshake and waits for its done pulse. It then returns the sum and overflow flag to the granted requester with a one-cycle acknowledge. It sits between the client blocks and the summation-unit datapath and is the only driver of that unit's inputs.

---
 rtl/escalonador_somador_if.sv | 42 ++++
 rtl/escalonador_somador.sv | 147 ++++++++++++++
 tb/tb_escalonador_somador.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/escalonador_somador_if.sv
`default_nettype none
// ============================================================================
// Module   : escalonador_somador_if
// Brief    : Client and summation-unit signals of the round-robin scheduler.
//            master = scheduler side, slave = clients plus summation unit.
// Revision : 1.0 - initial release
// ============================================================================
interface escalonador_somador_if #(
    parameter int W    = 6,
    parameter int NREQ = 4
);
    // Client side
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] valor_in;
    logic [NREQ-1:0]   ack;
    logic [W-1:0]      soma_out;
    logic              overflow_out;
    logic              erro_out;
    logic              ocupado;
    logic [NREQ-1:0]   atual;

    // Summation-unit side
    logic              su_inicio;
    logic [W-1:0]      su_valor;
    logic              su_pronto;
    logic [W-1:0]      su_soma;
    logic              su_overflow;

    modport master (
        input  req, valor_in, su_pronto, su_soma, su_overflow,
        output ack, soma_out, overflow_out, erro_out, ocupado, atual,
               su_inicio, su_valor
    );

    modport slave (
        output req, valor_in, su_pronto, su_soma, su_overflow,
        input  ack, soma_out, overflow_out, erro_out, ocupado, atual,
               su_inicio, su_valor
    );
endinterface

`default_nettype wire

// File: rtl/escalonador_somador.sv
`default_nettype none
// ============================================================================
// Module   : escalonador_somador
// Brief    : Round-robin scheduler sharing one summation unit among NREQ
//            requesters. Define ESCALONADOR_TIMEOUT_EN to bound the wait.
// Revision : 1.0 - initial release
// ============================================================================
module escalonador_somador #(
    parameter int W              = 6,
    parameter int NREQ           = 4,
    parameter int TIMEOUT_CICLOS = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    escalonador_somador_if.master bus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } estado_t;

    estado_t          r_estado;
    logic [IW-1:0]    r_ultimo;
    logic [IW-1:0]    r_idx;
    logic [NREQ-1:0]  r_ack;
    logic [NREQ-1:0]  r_atual;
    logic             r_inicio;
    logic [W-1:0]     r_valor;
    logic [W-1:0]     r_soma;
    logic             r_ovf;
    logic             r_ocupado;

`ifdef ESCALONADOR_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CICLOS + 1);
    logic [CW-1:0]    r_cnt;
    logic             r_erro;
`endif

    logic             w_hit;
    logic [IW-1:0]    w_idx;
    logic [IW-1:0]    w_pos;

    // Walk downward so the last hit kept is the first set bit above r_ultimo.
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        w_pos = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_pos = IW'((int'(r_ultimo) + k) % NREQ);
            if (bus.req[w_pos]) begin
                w_hit = 1'b1;
                w_idx = w_pos;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_estado  <= IDLE;
            r_ultimo  <= IW'(NREQ - 1);
            r_idx     <= '0;
            r_ack     <= '0;
            r_atual   <= '0;
            r_inicio  <= 1'b0;
            r_valor   <= '0;
            r_soma    <= '0;
            r_ovf     <= 1'b0;
            r_ocupado <= 1'b0;
`ifdef ESCALONADOR_TIMEOUT_EN
            r_cnt     <= '0;
            r_erro    <= 1'b0;
`endif
        end else begin
            r_inicio <= 1'b0;
            r_ack    <= '0;
            case (r_estado)
                IDLE: begin
                    if (w_hit) begin
                        r_idx     <= w_idx;
                        r_atual   <= {{(NREQ-1){1'b0}}, 1'b1} << w_idx;
                        r_valor   <= bus.valor_in[w_idx*W +: W];
                        r_inicio  <= 1'b1;
                        r_ocupado <= 1'b1;
                        r_estado  <= START;
                    end
                end
                START: begin
`ifdef ESCALONADOR_TIMEOUT_EN
                    r_cnt    <= '0;
`endif
                    r_estado <= WAIT;
                end
                WAIT: begin
                    if (bus.su_pronto) begin
                        r_soma   <= bus.su_soma;
                        r_ovf    <= bus.su_overflow;
`ifdef ESCALONADOR_TIMEOUT_EN
                        r_erro   <= 1'b0;
`endif
                        r_ack    <= r_atual;
                        r_estado <= DONE;
                    end
`ifdef ESCALONADOR_TIMEOUT_EN
                    // A completion on the limit cycle wins over the abort.
                    else if (r_cnt == CW'(TIMEOUT_CICLOS - 1)) begin
                        r_soma   <= '0;
                        r_ovf    <= 1'b0;
                        r_erro   <= 1'b1;
                        r_ack    <= r_atual;
                        r_estado <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    r_ultimo  <= r_idx;
                    r_atual   <= '0;
                    r_ocupado <= 1'b0;
                    r_estado  <= IDLE;
                end
                default: r_estado <= IDLE;
            endcase
        end
    end

    assign bus.ack          = r_ack;
    assign bus.atual        = r_atual;
    assign bus.ocupado      = r_ocupado;
    assign bus.su_inicio    = r_inicio;
    assign bus.su_valor     = r_valor;
    assign bus.soma_out     = r_soma;
    assign bus.overflow_out = r_ovf;
`ifdef ESCALONADOR_TIMEOUT_EN
    assign bus.erro_out     = r_erro;
`else
    assign bus.erro_out     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_escalonador_somador.sv
`default_nettype none
// ============================================================================
// Module   : tb_escalonador_somador
// Brief    : Self-checking bench for escalonador_somador (table, corner cases,
//            random traffic against a round-robin reference model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_escalonador_somador;

    localparam int W    = 6;
    localparam int NREQ = 4;
    localparam int TO   = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    escalonador_somador_if #(.W(W), .NREQ(NREQ)) bus ();

    escalonador_somador #(
        .W(W), .NREQ(NREQ), .TIMEOUT_CICLOS(TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int m_ultimo;

    typedef struct {
        logic [NREQ-1:0]   add;
        logic [NREQ*W-1:0] valores;
        int                lat;
        logic [W-1:0]      res;
        logic              ovf;
        bit                early;
        int                exp_idx;
    } vec_t;

    vec_t tab[5];

    task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nome, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference arbiter: first requester above the last one served, wrapping.
    function automatic int model_grant(input logic [NREQ-1:0] r);
        for (int k = 1; k <= NREQ; k++)
            if (r[(m_ultimo + k) % NREQ]) return (m_ultimo + k) % NREQ;
        return -1;
    endfunction

    task automatic do_txn(input logic [NREQ-1:0] add, input int lat, input logic [W-1:0] res,
                          input logic ovf, input bit early, input bit stir, input int exp_idx);
        logic [W-1:0]    exp_valor;
        logic [NREQ-1:0] onehot;
        bit              found;
        bus.req   = bus.req | add;
        onehot    = NREQ'(1) << exp_idx;
        exp_valor = bus.valor_in[exp_idx*W +: W];
        if (early) bus.su_pronto = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 8 && !found; c++) begin
            tick();
            if (bus.su_inicio === 1'b1) found = 1'b1;
        end
        chk("grant_seen", 32'(found), 32'd1);
        if (!found) begin
            bus.su_pronto = 1'b0;
            return;
        end
        chk("atual", 32'(bus.atual), 32'(onehot));
        chk("su_valor", 32'(bus.su_valor), 32'(exp_valor));
        chk("ocupado_busy", 32'(bus.ocupado), 32'd1);
        if (stir) begin
            bus.valor_in = (NREQ*W)'($urandom);
            bus.req      = bus.req | NREQ'($urandom);
        end
        for (int k = 0; k < lat; k++) begin
            tick();
            bus.su_pronto = 1'b0;
            chk("wait_quiet", 32'({bus.ack, bus.su_inicio, bus.ocupado, bus.su_valor}),
                32'({NREQ'(0), 1'b0, 1'b1, exp_valor}));
        end
        bus.su_soma     = res;
        bus.su_overflow = ovf;
        bus.su_pronto   = 1'b1;
        tick();
        bus.su_pronto   = 1'b0;
        bus.su_soma     = W'($urandom);
        bus.su_overflow = 1'($urandom);
        chk("ack", 32'(bus.ack), 32'(onehot));
        chk("soma_out", 32'(bus.soma_out), 32'(res));
        chk("overflow_out", 32'(bus.overflow_out), 32'(ovf));
        chk("erro_out", 32'(bus.erro_out), 32'd0);
        m_ultimo = exp_idx;
        tick();
        bus.req[exp_idx] = 1'b0;
        chk("after_done", 32'({bus.ack, bus.atual, bus.ocupado, bus.su_inicio}), 32'd0);
        chk("result_held", 32'({bus.soma_out, bus.overflow_out}), 32'({res, ovf}));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [NREQ-1:0] add;
        bit found;

        tab[0] = '{4'b0001, {6'd9, 6'd40, 6'd17, 6'd5},  4, 6'd20, 1'b0, 1'b0, 0};
        tab[1] = '{4'b0010, {6'd9, 6'd40, 6'd16, 6'd5},  2, 6'd0,  1'b1, 1'b0, 1};
        tab[2] = '{4'b0100, {6'd9, 6'd33, 6'd16, 6'd5},  1, 6'd41, 1'b0, 1'b1, 2};
        tab[3] = '{4'b1001, {6'd62, 6'd33, 6'd16, 6'd3}, 3, 6'd63, 1'b1, 1'b0, 3};
        tab[4] = '{4'b0000, {6'd62, 6'd33, 6'd16, 6'd27}, 1, 6'd7, 1'b0, 1'b0, 0};

        bus.req = '0; bus.valor_in = '0;
        bus.su_pronto = 1'b0; bus.su_soma = '0; bus.su_overflow = 1'b0;
        tick(); tick();
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_atual", 32'(bus.atual), 32'd0);
        chk("rst_ocupado", 32'(bus.ocupado), 32'd0);
        chk("rst_su_inicio", 32'(bus.su_inicio), 32'd0);
        chk("rst_su_valor", 32'(bus.su_valor), 32'd0);
        chk("rst_soma", 32'(bus.soma_out), 32'd0);
        chk("rst_ovf", 32'(bus.overflow_out), 32'd0);
        chk("rst_erro", 32'(bus.erro_out), 32'd0);
        reset = 1'b1;
        m_ultimo = NREQ - 1;
        tick();

        for (int i = 0; i < 5; i++) begin
            bus.valor_in = tab[i].valores;
            do_txn(tab[i].add, tab[i].lat, tab[i].res, tab[i].ovf, tab[i].early, 1'b0, tab[i].exp_idx);
        end

        // su_pronto while idle with nothing requested
        bus.su_pronto = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("idle_pronto", 32'({bus.ack, bus.ocupado}), 32'd0);
        end
        bus.su_pronto = 1'b0;

        // Reset in the middle of WAIT
        bus.req = 4'b0010;
        bus.valor_in = {6'd1, 6'd2, 6'd3, 6'd4};
        tick();
        chk("mid_start", 32'(bus.su_inicio), 32'd1);
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_mid_outputs", 32'({bus.ack, bus.atual, bus.ocupado, bus.su_inicio, bus.su_valor,
                                    bus.soma_out, bus.overflow_out, bus.erro_out}), 32'd0);
        bus.su_pronto = 1'b1;
        tick();
        chk("rst_hold", 32'({bus.ack, bus.ocupado, bus.soma_out}), 32'd0);
        bus.su_pronto = 1'b0;
        bus.req = '0;
        reset = 1'b1;
        m_ultimo = NREQ - 1;
        tick();

        // All requesting: rotation restarts at 0
        bus.valor_in = {6'd44, 6'd33, 6'd22, 6'd11};
        do_txn(4'b1111, 2, 6'd10, 1'b0, 1'b0, 1'b0, 0);
        do_txn(4'b0000, 1, 6'd11, 1'b0, 1'b0, 1'b0, 1);
        do_txn(4'b0000, 3, 6'd12, 1'b1, 1'b0, 1'b0, 2);
        do_txn(4'b0000, 1, 6'd13, 1'b0, 1'b0, 1'b0, 3);
        chk("all_req_drained", 32'(bus.req), 32'd0);

        // Random traffic against the reference arbiter
        for (int i = 0; i < 40; i++) begin
            bus.valor_in = (NREQ*W)'($urandom);
            if (bus.req == '0 || $urandom_range(0, 1) == 1)
                add = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            else
                add = '0;
            bus.req = bus.req | add;
            do_txn('0, $urandom_range(1, 5), W'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), model_grant(bus.req));
        end
        bus.req = '0;
        tick(); tick();

        // Summation unit never answers
        bus.valor_in = {6'd0, 6'd0, 6'd0, 6'd19};
        bus.req = 4'b0001;
        found = 1'b0;
        for (int c = 0; c < 8 && !found; c++) begin
            tick();
            if (bus.su_inicio === 1'b1) found = 1'b1;
        end
        chk("to_grant_seen", 32'(found), 32'd1);
`ifdef ESCALONADOR_TIMEOUT_EN
        for (int k = 0; k < TO; k++) begin
            tick();
            chk("to_wait", 32'({bus.ack, bus.ocupado}), 32'd1);
        end
        tick();
        chk("to_ack", 32'(bus.ack), 32'd1);
        chk("to_erro", 32'(bus.erro_out), 32'd1);
        chk("to_soma", 32'({bus.soma_out, bus.overflow_out}), 32'd0);
        m_ultimo = 0;
        tick();
        bus.req = '0;
        bus.su_pronto = 1'b1;
        tick();
        bus.su_pronto = 1'b0;
        chk("late_pronto", 32'({bus.ack, bus.ocupado, bus.erro_out}), 32'd1);
`else
        for (int k = 0; k < 40; k++) begin
            tick();
            chk("no_to_busy", 32'({bus.ack, bus.ocupado, bus.erro_out}), 32'b0010);
        end
        bus.req = '0;
        reset = 1'b0;
        tick();
        chk("no_to_reset", 32'(bus.ocupado), 32'd0);
        reset = 1'b1;
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
